// File: rtl/seq_det_arbiter.sv
// Round-robin time-sharing of one 1001 Moore detector among NREQ bit streams.
// Optional build macro SEQ_ARB_FIXED_PRI_EN selects fixed lowest-index priority.
module seq_det_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int BURST = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  x_in,
  output logic [NREQ-1:0]  gnt,
  output logic             det_reset,
  output logic             det_x,
  input  logic             det_z,
  output logic             busy,
  output logic             done,
  output logic [IDW-1:0]   done_id,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   g_q, g_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             valid_q, valid_d;
  logic             det_reset_q, det_reset_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [IDW-1:0]   win;
  logic             consume;
  logic             hit;

`ifndef SEQ_ARB_FIXED_PRI_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             found;
`endif

  assign consume   = (state_q == RUN) && |(gnt_q & req);
  assign hit       = valid_q & det_z;
  assign gnt       = gnt_q;
  assign det_x     = |(gnt_q & x_in);
  assign det_reset = det_reset_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

  // Winner selection: the search order starts just after the last grant.
  always_comb begin
    win = '0;
`ifdef SEQ_ARB_FIXED_PRI_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) win = IDW'(k);
    end
`else
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
        win   = IDW'((int'(ptr_q) + k) % NREQ);
        found = 1'b1;
      end
    end
`endif
  end

  // Next-state logic for the IDLE/RUN/DRAIN burst controller.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q + CNT_W'(hit);
    valid_d     = 1'b0;
    det_reset_d = det_reset_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
`ifndef SEQ_ARB_FIXED_PRI_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = RUN;
          gnt_d       = NREQ'(1) << win;
          g_d         = win;
          cnt_d       = '0;
          acc_d       = '0;
          det_reset_d = 1'b0;
`ifndef SEQ_ARB_FIXED_PRI_EN
          ptr_d       = win;
`endif
        end
      end
      RUN: begin
        valid_d = consume;
        if (consume) cnt_d = cnt_q + 8'd1;
        if (!consume || cnt_q == 8'(BURST - 1)) begin
          state_d = DRAIN;
          gnt_d   = '0;
        end
      end
      DRAIN: begin
        state_d     = IDLE;
        det_reset_d = 1'b1;
        done_d      = 1'b1;
        done_id_d   = g_q;
        match_cnt_d = acc_d;
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        det_reset_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset discards any partial burst.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      g_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      valid_q     <= 1'b0;
      det_reset_q <= 1'b1;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
`ifndef SEQ_ARB_FIXED_PRI_EN
      ptr_q       <= IDW'(NREQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      valid_q     <= valid_d;
      det_reset_q <= det_reset_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
`ifndef SEQ_ARB_FIXED_PRI_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

endmodule
